// File: rtl/div_pkg.sv
// Shared definitions for the shift-subtract divider: default width,
// one-hot controller states and the iteration counter sizing.
package div_pkg;

    // Default divisor/remainder width; dividend and quotient are twice this.
    localparam int DIV_W = 4;

    // One-hot state vector width.
    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        S_IDLE = 3'b001,
        S_INIT = 3'b010,
        S_STEP = 3'b100
    } state_e;

    // Counter must hold 0 .. 2W-1 with a spare bit so it never wraps mid-operation.
    function automatic int cnt_width(input int w);
        return $clog2(2 * w) + 1;
    endfunction

endpackage

// File: rtl/div_datapath.sv
// Divider datapath: holds divisor, quotient/dividend shift register and
// partial remainder, and performs one restoring trial subtract per step.
module div_datapath
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic           step_i,
    input  logic           dz_i,
    input  logic [2*W-1:0] dividend_i,
    input  logic [W-1:0]   divisor_i,
    output logic [2*W-1:0] quotient_o,
    output logic [W-1:0]   remainder_o,
    output logic           div_by_zero_o
);

    logic [W-1:0]   d_q, d_d;
    logic [2*W-1:0] q_q, q_d;
    logic [W-1:0]   r_q, r_d;
    logic           dz_q, dz_d;

    // Partial remainder after the shift is W+1 bits wide, so the trial
    // compare cannot overflow. A stored remainder is always below the divisor,
    // so only W bits need to be kept between steps.
    logic [W:0]     r_shift;
    logic           fits;
    logic [W-1:0]   diff;

    // Trial subtract and next-state selection for all datapath registers.
    always_comb begin
        r_shift = {r_q, q_q[2*W-1]};
        fits    = (r_shift >= {1'b0, d_q});
        // When the subtract is taken the true difference is below the divisor,
        // so a W-bit modular subtract gives the exact result.
        diff    = r_shift[W-1:0] - d_q;

        d_d  = d_q;
        q_d  = q_q;
        r_d  = r_q;
        dz_d = dz_q;

        if (load_i) begin
            d_d  = divisor_i;
            dz_d = dz_i;
            r_d  = '0;
            if (dz_i) begin
                q_d = '1;
            end else begin
                q_d = dividend_i;
            end
        end else if (step_i) begin
            if (fits) begin
                r_d = diff;
                q_d = {q_q[2*W-2:0], 1'b1};
            end else begin
                r_d = r_shift[W-1:0];
                q_d = {q_q[2*W-2:0], 1'b0};
            end
        end
    end

    // Datapath registers, cleared asynchronously so an aborted result is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q  <= '0;
            q_q  <= '0;
            r_q  <= '0;
            dz_q <= 1'b0;
        end else begin
            d_q  <= d_d;
            q_q  <= q_d;
            r_q  <= r_d;
            dz_q <= dz_d;
        end
    end

    assign quotient_o    = q_q;
    assign remainder_o   = r_q;
    assign div_by_zero_o = dz_q;

endmodule

// File: rtl/div_shift_subtract.sv
// Sequential restoring divider: 2W-bit dividend by W-bit divisor, one
// quotient bit per clock, start/ready handshake shared with the multiplier.
module div_shift_subtract
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*W-1:0] dividendBus,
    input  logic [W-1:0]   divisorBus,
    output logic           ready,
    output logic [2*W-1:0] quotientBus,
    output logic [W-1:0]   remainderBus,
    output logic           divByZero
);

    localparam int CNT_W = cnt_width(W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(2 * W - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             load_en;
    logic             step_en;
    logic             div_zero;

    // Next-state, counter and datapath control decode.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        load_en  = 1'b0;
        step_en  = 1'b0;
        div_zero = (divisorBus == '0);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                load_en = 1'b1;
                count_d = '0;
                // A zero divisor finishes immediately with the saturated quotient.
                state_d = div_zero ? S_IDLE : S_STEP;
            end
            S_STEP: begin
                step_en = 1'b1;
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_STEP) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                // Recover from any illegal one-hot encoding.
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    // State and iteration counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign ready = (state_q == S_IDLE);

    div_datapath #(
        .W(W)
    ) u_datapath (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load_en),
        .step_i       (step_en),
        .dz_i         (div_zero),
        .dividend_i   (dividendBus),
        .divisor_i    (divisorBus),
        .quotient_o   (quotientBus),
        .remainder_o  (remainderBus),
        .div_by_zero_o(divByZero)
    );

endmodule
